// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues 4-byte-aligned instruction fetches, buffers in-order responses
// in a DEPTH-entry FIFO and hands {pc, instr} to decode; redirects flush the queue.
module instr_fetch_queue #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [63:0] id_pc
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned CW1 = CW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW:0]   DEPTH_W = CW1'(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic {RUN, FLUSH} state_e;

  state_e        state_q, state_d;
  logic [63:0]   fetch_pc_q;
  logic          req_en_q;
  logic [CW-1:0] count_q, outstanding_q, drop_q;
  logic [CW-1:0] count_d, outstanding_d, drop_d;
  logic [AW-1:0] head_q, tail_q, fl_head_q, fl_tail_q;
  logic [CW:0]   credits_used;
  logic          req_fire, rsp_ok, push, pop;

  // Decode-side FIFO plus the PCs of requests still in flight to memory.
  logic [31:0] instr_mem     [DEPTH];
  logic [63:0] pc_mem        [DEPTH];
  logic [63:0] flight_pc_mem [DEPTH];

  // NOTE: every signal driven here gets a value before any branch, so no latch is inferred.
  always_comb begin
    credits_used   = {1'b0, count_q} + {1'b0, outstanding_q};
    imem_req_valid = req_en_q && (state_q == RUN) && !redirect_valid && (credits_used < DEPTH_W);
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    rsp_ok         = imem_rsp_valid && (outstanding_q != '0);
    id_valid       = (state_q == RUN) && (count_q != '0);
    id_instr       = id_valid ? instr_mem[head_q] : NOP;
    id_pc          = id_valid ? pc_mem[head_q] : 64'h0;
    push           = rsp_ok && (drop_q == '0) && !redirect_valid;
    pop            = id_valid && id_ready && !redirect_valid;
    outstanding_d  = outstanding_q + CW'(req_fire) - CW'(rsp_ok);
    count_d        = redirect_valid ? '0 : (count_q + CW'(push) - CW'(pop));

    drop_d = drop_q;
    if (redirect_valid && (state_q == RUN)) begin
      drop_d = outstanding_d;
    end else if (rsp_ok && (drop_q != '0)) begin
      drop_d = drop_q - CW'(1);
    end

    state_d = state_q;
    case (state_q)
      RUN:   if (redirect_valid && (outstanding_d != '0)) state_d = FLUSH;
      FLUSH: if (drop_d == '0) state_d = RUN;
    endcase
  end

  // req_en_q holds off requests for the first cycle after reset so the memory
  // side sees an idle cycle while it comes out of its own reset.
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= RUN;
      fetch_pc_q    <= RESET_PC;
      req_en_q      <= 1'b0;
      count_q       <= '0;
      outstanding_q <= '0;
      drop_q        <= '0;
      head_q        <= '0;
      tail_q        <= '0;
      fl_head_q     <= '0;
      fl_tail_q     <= '0;
    end else begin
      state_q       <= state_d;
      req_en_q      <= 1'b1;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      drop_q        <= drop_d;

      if (redirect_valid) begin
        fetch_pc_q <= redirect_pc & ~64'h3;
      end else if (req_fire) begin
        fetch_pc_q <= fetch_pc_q + 64'd4;
      end

      if (redirect_valid) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= tail_q + AW'(1);
        if (pop)  head_q <= head_q + AW'(1);
      end

      // In-flight PC queue keeps draining across redirects: discarded responses still pop it.
      if (req_fire) fl_tail_q <= fl_tail_q + AW'(1);
      if (rsp_ok)   fl_head_q <= fl_head_q + AW'(1);
    end
  end

  // NOTE: storage arrays are not reset; pointers and count gate every read, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (req_fire) flight_pc_mem[fl_tail_q] <= fetch_pc_q;
    if (push) begin
      instr_mem[tail_q] <= imem_rsp_data;
      pc_mem[tail_q]    <= flight_pc_mem[fl_head_q];
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    (count_q <= DEPTH_C) && (outstanding_q <= DEPTH_C));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: a latency-randomised memory model plus
// a stream-level reference (sequential PCs from each redirect target) checked every cycle.
module tb_instr_fetch_queue;
  localparam logic [63:0] RESET_PC = 64'h1000;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic        redirect_valid, id_valid, id_ready;
  logic [63:0] imem_req_addr, redirect_pc, id_pc;
  logic [31:0] imem_rsp_data, id_instr;

  instr_fetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          epoch;
  } rsp_t;

  rsp_t        rsp_q[$];
  logic [63:0] req_log[$];
  int          n_tests = 0, n_fail = 0;
  int          cyc = 0, epoch = 0, last_due = 0, buffered = 0;
  int          lat_min = 1, lat_max = 1;
  int          n_acc = 0, n_id_fire = 0, n_old_rsp = 0, last_old_rsp_cyc = -1;
  int          first_req_cyc = -1;
  logic [63:0] first_req_addr, last_id_pc;
  logic [63:0] exp_req_pc = RESET_PC, exp_id_pc = RESET_PC;
  bit          drv_rst = 1'b1, drv_req_ready = 1'b0, drv_id_ready = 1'b0, drv_redirect = 1'b0;
  logic [63:0] drv_redirect_pc = 64'h0;
  bit          first_after_reset = 1'b0, log_reqs = 1'b0, want_first_req = 1'b0;

  function automatic logic [31:0] instr_of(input logic [63:0] pc);
    return pc[33:2] ^ {pc[63:48], pc[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // One clock cycle: drive at negedge, sample 1ns later, update the reference model.
  task automatic step();
    bit   rsp_now, exp_req_valid, exp_id_valid, req_fire, id_fire;
    int   rsp_epoch, old_inflight, due;
    rsp_t ent;
    @(negedge clk);
    rst_n          = !drv_rst;
    imem_req_ready = drv_req_ready;
    id_ready       = drv_id_ready;
    redirect_valid = drv_redirect;
    redirect_pc    = drv_redirect_pc;
    rsp_now        = 1'b0;
    rsp_epoch      = 0;
    if (!drv_rst && (rsp_q.size() != 0) && (rsp_q[0].due <= cyc)) begin
      rsp_now   = 1'b1;
      rsp_epoch = rsp_q[0].epoch;
    end
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? instr_of(rsp_q[0].addr) : 32'h0;
    #1;
    if (drv_rst) begin
      rsp_q.delete();
      buffered          = 0;
      exp_req_pc        = RESET_PC;
      exp_id_pc         = RESET_PC;
      first_after_reset = 1'b1;
      last_due          = cyc;
      epoch++;
      cyc++;
      return;
    end

    old_inflight = 0;
    foreach (rsp_q[i]) if (rsp_q[i].epoch != epoch) old_inflight++;
    exp_req_valid = !first_after_reset && !drv_redirect && (old_inflight == 0) &&
                    ((rsp_q.size() + buffered) < DEPTH);
    exp_id_valid  = (buffered != 0);

    n_tests++;
    if (imem_req_valid !== exp_req_valid) begin
      n_fail++;
      $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_req_valid);
    end
    if (exp_req_valid) begin
      n_tests++;
      if (imem_req_addr !== exp_req_pc) begin
        n_fail++;
        $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_req_addr, exp_req_pc);
      end
    end
    n_tests++;
    if (id_valid !== exp_id_valid) begin
      n_fail++;
      $display("FAIL id_valid cyc=%0d: got %b expected %b", cyc, id_valid, exp_id_valid);
    end
    n_tests++;
    if (exp_id_valid) begin
      if ((id_pc !== exp_id_pc) || (id_instr !== instr_of(exp_id_pc))) begin
        n_fail++;
        $display("FAIL id_head cyc=%0d: got pc=%h instr=%h expected pc=%h instr=%h",
                 cyc, id_pc, id_instr, exp_id_pc, instr_of(exp_id_pc));
      end
    end else if ((id_pc !== 64'h0) || (id_instr !== NOP)) begin
      n_fail++;
      $display("FAIL id_empty cyc=%0d: got pc=%h instr=%h expected pc=0 instr=%h",
               cyc, id_pc, id_instr, NOP);
    end

    req_fire = (imem_req_valid === 1'b1) && drv_req_ready;
    id_fire  = exp_id_valid && drv_id_ready && !drv_redirect;
    if (rsp_now) begin
      if (rsp_epoch != epoch) begin
        n_old_rsp++;
        last_old_rsp_cyc = cyc;
      end else if (!drv_redirect) begin
        buffered++;
      end
      void'(rsp_q.pop_front());
    end
    if (id_fire) begin
      buffered--;
      n_id_fire++;
      last_id_pc = exp_id_pc;
      exp_id_pc += 64'd4;
    end
    if (req_fire) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due  = due;
      ent.addr  = imem_req_addr;
      ent.due   = due;
      ent.epoch = epoch;
      rsp_q.push_back(ent);
      n_acc++;
      if (log_reqs) req_log.push_back(imem_req_addr);
      if (want_first_req) begin
        want_first_req = 1'b0;
        first_req_cyc  = cyc;
        first_req_addr = imem_req_addr;
      end
      exp_req_pc += 64'd4;
    end
    if (drv_redirect) begin
      epoch++;
      buffered   = 0;
      exp_req_pc = drv_redirect_pc & ~64'h3;
      exp_id_pc  = exp_req_pc;
    end
    first_after_reset = 1'b0;
    cyc++;
  endtask

  task automatic do_reset();
    drv_rst      = 1'b1;
    drv_redirect = 1'b0;
    step();
    step();
    drv_rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lat_min = 1; lat_max = 1;
    drv_req_ready = 1'b1; drv_id_ready = 1'b1;
    req_log.delete(); log_reqs = 1'b1;
    step();
    n_tests++;
    if ((imem_req_valid !== 1'b0) || (id_valid !== 1'b0) || (id_instr !== NOP) || (id_pc !== 64'h0)) begin
      n_fail++;
      $display("FAIL reset_outputs: got req_valid=%b id_valid=%b instr=%h pc=%h expected 0 0 %h 0",
               imem_req_valid, id_valid, id_instr, id_pc, NOP);
    end
    step();
    n_tests++;
    if ((imem_req_valid !== 1'b1) || (imem_req_addr !== RESET_PC)) begin
      n_fail++;
      $display("FAIL reset_first_req: got valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
  endtask

  task automatic test_stream();
    int p0;
    logic [63:0] a0, a1, a2;
    for (int i = 0; i < 6; i++) step();
    p0 = n_id_fire;
    for (int i = 0; i < 20; i++) step();
    n_tests++;
    if (n_id_fire - p0 != 20) begin
      n_fail++;
      $display("FAIL stream_no_gaps: got %0d pops in 20 cycles expected 20", n_id_fire - p0);
    end
    log_reqs = 1'b0;
    a0 = req_log[0]; a1 = req_log[1]; a2 = req_log[2];
    n_tests++;
    if ((a0 !== 64'h1000) || (a1 !== 64'h1004) || (a2 !== 64'h1008)) begin
      n_fail++;
      $display("FAIL stream_addrs: got %h %h %h expected 1000 1004 1008", a0, a1, a2);
    end
  endtask

  task automatic test_backpressure();
    int a0, p0;
    do_reset();
    lat_min = 1; lat_max = 1;
    drv_req_ready = 1'b1; drv_id_ready = 1'b0;
    a0 = n_acc;
    for (int i = 0; i < 12; i++) step();
    n_tests++;
    if ((n_acc - a0 != DEPTH) || (imem_req_valid !== 1'b0)) begin
      n_fail++;
      $display("FAIL bp_credit_cap: got %0d requests req_valid=%b expected %0d 0", n_acc - a0, imem_req_valid, DEPTH);
    end
    drv_id_ready = 1'b1;
    p0 = n_id_fire;
    for (int i = 0; i < 12; i++) step();
    n_tests++;
    if (n_id_fire - p0 != 12) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d pops expected 12", n_id_fire - p0);
    end
  endtask

  task automatic test_flush();
    int a0, o0, f0, guard;
    do_reset();
    lat_min = 6; lat_max = 6;
    drv_req_ready = 1'b1; drv_id_ready = 1'b1;
    a0 = n_acc;
    guard = 0;
    while ((n_acc - a0 < 3) && (guard < 20)) begin step(); guard++; end
    o0 = n_old_rsp;
    drv_redirect = 1'b1; drv_redirect_pc = 64'h2002; want_first_req = 1'b1;
    step();
    drv_redirect = 1'b0;
    guard = 0;
    while (want_first_req && (guard < 40)) begin step(); guard++; end
    n_tests++;
    if (want_first_req || (first_req_addr !== 64'h2000)) begin
      n_fail++;
      $display("FAIL flush_target: got addr=%h pending=%b expected 2000 0", first_req_addr, want_first_req);
    end
    want_first_req = 1'b0;
    n_tests++;
    if ((n_old_rsp - o0 != 3) || (first_req_cyc != last_old_rsp_cyc + 1)) begin
      n_fail++;
      $display("FAIL flush_timing: got %0d discarded, req cyc %0d last drop cyc %0d expected 3 and +1",
               n_old_rsp - o0, first_req_cyc, last_old_rsp_cyc);
    end
    f0 = n_id_fire;
    guard = 0;
    while ((n_id_fire == f0) && (guard < 20)) begin step(); guard++; end
    n_tests++;
    if ((n_id_fire == f0) || (last_id_pc !== 64'h2000)) begin
      n_fail++;
      $display("FAIL flush_first_id: got pc=%h fired=%0d expected 2000", last_id_pc, n_id_fire - f0);
    end
  endtask

  task automatic test_redirect_push_pop();
    int f0, guard;
    logic [63:0] popped;
    do_reset();
    lat_min = 1; lat_max = 1;
    drv_req_ready = 1'b1; drv_id_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    drv_redirect = 1'b1; drv_redirect_pc = 64'h3000;
    step();
    popped = id_pc;
    n_tests++;
    if ((id_valid !== 1'b1) || (imem_rsp_valid !== 1'b1)) begin
      n_fail++;
      $display("FAIL rpp_setup: got id_valid=%b rsp_valid=%b expected 1 1", id_valid, imem_rsp_valid);
    end
    drv_redirect = 1'b0;
    step();
    n_tests++;
    if (id_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rpp_empty: got id_valid=%b expected 0", id_valid);
    end
    f0 = n_id_fire;
    guard = 0;
    while ((n_id_fire == f0) && (guard < 20)) begin step(); guard++; end
    n_tests++;
    if ((last_id_pc !== 64'h3000) || (last_id_pc === popped)) begin
      n_fail++;
      $display("FAIL rpp_next: got pc=%h (popped %h) expected 3000", last_id_pc, popped);
    end
  endtask

  task automatic test_wrap();
    int guard;
    logic [63:0] w0, w1;
    do_reset();
    lat_min = 1; lat_max = 2;
    drv_req_ready = 1'b1; drv_id_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    drv_redirect = 1'b1; drv_redirect_pc = 64'hFFFF_FFFF_FFFF_FFFE;
    req_log.delete(); log_reqs = 1'b1;
    step();
    drv_redirect = 1'b0;
    guard = 0;
    while ((req_log.size() < 2) && (guard < 30)) begin step(); guard++; end
    log_reqs = 1'b0;
    w0 = (req_log.size() > 0) ? req_log[0] : 64'hX;
    w1 = (req_log.size() > 1) ? req_log[1] : 64'hX;
    n_tests++;
    if ((w0 !== 64'hFFFF_FFFF_FFFF_FFFC) || (w1 !== 64'h0)) begin
      n_fail++;
      $display("FAIL wrap_addr: got %h %h expected fffffffffffffffc 0", w0, w1);
    end
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_reset_midop();
    int a0, guard;
    do_reset();
    lat_min = 3; lat_max = 3;
    drv_req_ready = 1'b1; drv_id_ready = 1'b0;
    a0 = n_acc;
    guard = 0;
    while (((n_acc - a0 < DEPTH) || (buffered < 2)) && (guard < 30)) begin step(); guard++; end
    n_tests++;
    if ((buffered != 2) || (rsp_q.size() != 2) || (imem_req_valid !== 1'b0) || (id_valid !== 1'b1)) begin
      n_fail++;
      $display("FAIL midop_setup: got buffered=%0d inflight=%0d req_valid=%b id_valid=%b expected 2 2 0 1",
               buffered, rsp_q.size(), imem_req_valid, id_valid);
    end
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0;
    step();
    n_tests++;
    if ((imem_req_valid !== 1'b0) || (id_valid !== 1'b0) || (id_instr !== NOP) || (id_pc !== 64'h0)) begin
      n_fail++;
      $display("FAIL midop_reset: got req_valid=%b id_valid=%b instr=%h pc=%h expected 0 0 %h 0",
               imem_req_valid, id_valid, id_instr, id_pc, NOP);
    end
    step();
    n_tests++;
    if ((imem_req_valid !== 1'b1) || (imem_req_addr !== RESET_PC)) begin
      n_fail++;
      $display("FAIL midop_first_req: got valid=%b addr=%h expected 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    drv_id_ready = 1'b1;
    for (int i = 0; i < 10; i++) step();
  endtask

  task automatic test_random();
    int p0;
    do_reset();
    lat_min = 1; lat_max = 4;
    p0 = n_id_fire;
    for (int i = 0; i < 1500; i++) begin
      drv_req_ready   = ($urandom_range(9, 0) < 7);
      drv_id_ready    = ($urandom_range(9, 0) < 7);
      drv_redirect    = ($urandom_range(39, 0) == 0);
      drv_redirect_pc = {$urandom, $urandom};
      drv_rst         = ($urandom_range(499, 0) == 0);
      step();
    end
    drv_rst = 1'b0; drv_redirect = 1'b0;
    n_tests++;
    if (n_id_fire - p0 < 300) begin
      n_fail++;
      $display("FAIL random_progress: got %0d pops expected at least 300", n_id_fire - p0);
    end
  endtask

  initial begin
    rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 64'h0; id_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_redirect_push_pop();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
